// File: rtl/scope_mode_ctrl.sv
// Scope mode controller: key/CPU arbitration onto mode registers, AD clock switch sequencer, FFT start handshake.
// Optional feature macro SCOPE_MODE_CTRL_READBACK_EN enables the cpu_rdata readback mux.
module scope_mode_ctrl #(
    parameter int unsigned GATE_CYC    = 16,
    parameter int unsigned SETTLE_CYC  = 64,
    parameter int unsigned ADCLK_MODES = 5
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic        key_wave_p,
    input  logic        key_frq_p,
    input  logic        key_adda_p,
    input  logic        key_adclk_p,
    input  logic        key_hor_p,
    input  logic        key_fft_p,
    input  logic        fft_done,
    input  logic        cpu_wr_en,
    input  logic [2:0]  cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic [1:0]  mode_wave,
    output logic [13:0] phase_inc,
    output logic        sel_adda,
    output logic [2:0]  ad_clk_sel,
    output logic        ad_clk_en,
    output logic [4:0]  par_hor,
    output logic        fft_start_pulse,
    output logic        fft_armed,
    output logic        adclk_busy,
    output logic        cfg_err
);

    localparam int unsigned CNT_MAX = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [2:0] ADCLK_LAST = 3'(ADCLK_MODES - 1);
    localparam logic [7:0] ADCLK_LIM  = 8'(ADCLK_MODES);

    localparam logic [2:0] A_WAVE  = 3'd0;
    localparam logic [2:0] A_FRQ   = 3'd1;
    localparam logic [2:0] A_ADDA  = 3'd2;
    localparam logic [2:0] A_ADCLK = 3'd3;
    localparam logic [2:0] A_HOR   = 3'd4;
    localparam logic [2:0] A_CTRL  = 3'd5;
    localparam logic [2:0] A_STAT  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GATE,
        ST_SWITCH,
        ST_SETTLE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       wave_q, wave_d;
    logic [1:0]       frq_q, frq_d;
    logic             adda_q, adda_d;
    logic [2:0]       adclk_q, adclk_d;
    logic [1:0]       hor_q, hor_d;
    logic [13:0]      phase_inc_q, phase_inc_d;
    logic [4:0]       par_hor_q, par_hor_d;
    logic [2:0]       ad_clk_sel_q, ad_clk_sel_d;
    logic             ad_clk_en_q, ad_clk_en_d;
    logic             adclk_busy_q, adclk_busy_d;
    logic             fft_start_q, fft_start_d;
    logic             fft_armed_q, fft_armed_d;
    logic             cfg_err_q, cfg_err_d;
    logic             busy;
    logic             fft_req;

    // Next-state: field arbitration (CPU beats key on the same field), FFT handshake, clock-switch FSM
    always_comb begin
        wave_d       = wave_q;
        frq_d        = frq_q;
        adda_d       = adda_q;
        adclk_d      = adclk_q;
        hor_d        = hor_q;
        cfg_err_d    = 1'b0;
        fft_start_d  = 1'b0;
        fft_armed_d  = fft_armed_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        ad_clk_sel_d = ad_clk_sel_q;
        busy         = (state_q != ST_IDLE);
        fft_req      = key_fft_p | (cpu_wr_en & (cpu_addr == A_CTRL) & cpu_wdata[0]);

        if (key_wave_p && !(cpu_wr_en && cpu_addr == A_WAVE)) wave_d = wave_q + 2'd1;
        if (key_frq_p && !(cpu_wr_en && cpu_addr == A_FRQ))
            frq_d = (frq_q == 2'd2) ? 2'd0 : frq_q + 2'd1;
        if (key_adda_p && !(cpu_wr_en && cpu_addr == A_ADDA)) adda_d = ~adda_q;
        if (key_adclk_p && !busy && !(cpu_wr_en && cpu_addr == A_ADCLK))
            adclk_d = (adclk_q >= ADCLK_LAST) ? 3'd0 : adclk_q + 3'd1;
        if (key_hor_p && !(cpu_wr_en && cpu_addr == A_HOR)) hor_d = hor_q + 2'd1;

        if (cpu_wr_en) begin
            case (cpu_addr)
                A_WAVE:  if (cpu_wdata <= 8'd3) wave_d = cpu_wdata[1:0]; else cfg_err_d = 1'b1;
                A_FRQ:   if (cpu_wdata <= 8'd2) frq_d = cpu_wdata[1:0]; else cfg_err_d = 1'b1;
                A_ADDA:  if (cpu_wdata <= 8'd1) adda_d = cpu_wdata[0]; else cfg_err_d = 1'b1;
                // Writes during a clock switch are silently dropped
                A_ADCLK: if (!busy) begin
                    if (cpu_wdata < ADCLK_LIM) adclk_d = cpu_wdata[2:0];
                    else cfg_err_d = 1'b1;
                end
                A_HOR:   if (cpu_wdata <= 8'd3) hor_d = cpu_wdata[1:0]; else cfg_err_d = 1'b1;
                A_CTRL:  begin end
                default: cfg_err_d = 1'b1;
            endcase
        end

        if (fft_done) begin
            fft_armed_d = 1'b0;
        end else if (fft_req && !fft_armed_q) begin
            fft_start_d = 1'b1;
            fft_armed_d = 1'b1;
        end

        // The SWITCH cycle counts toward the settle time after ad_clk_sel moves
        case (state_q)
            ST_IDLE: begin
                if (adclk_d != adclk_q) begin
                    state_d = ST_GATE;
                    cnt_d   = '0;
                end
            end
            ST_GATE: begin
                if (cnt_q == GATE_LAST) begin
                    state_d      = ST_SWITCH;
                    cnt_d        = '0;
                    ad_clk_sel_d = adclk_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SWITCH: begin
                state_d = ST_SETTLE;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        ad_clk_en_d  = (state_d == ST_IDLE);
        adclk_busy_d = (state_d != ST_IDLE);
        phase_inc_d  = 14'd1 << frq_d;
        par_hor_d    = {3'b000, hor_d} + 5'd1;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            wave_q       <= 2'd0;
            frq_q        <= 2'd0;
            adda_q       <= 1'b0;
            adclk_q      <= 3'd0;
            hor_q        <= 2'd0;
            phase_inc_q  <= 14'd1;
            par_hor_q    <= 5'd1;
            ad_clk_sel_q <= 3'd0;
            ad_clk_en_q  <= 1'b1;
            adclk_busy_q <= 1'b0;
            fft_start_q  <= 1'b0;
            fft_armed_q  <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wave_q       <= wave_d;
            frq_q        <= frq_d;
            adda_q       <= adda_d;
            adclk_q      <= adclk_d;
            hor_q        <= hor_d;
            phase_inc_q  <= phase_inc_d;
            par_hor_q    <= par_hor_d;
            ad_clk_sel_q <= ad_clk_sel_d;
            ad_clk_en_q  <= ad_clk_en_d;
            adclk_busy_q <= adclk_busy_d;
            fft_start_q  <= fft_start_d;
            fft_armed_q  <= fft_armed_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign mode_wave       = wave_q;
    assign phase_inc       = phase_inc_q;
    assign sel_adda        = adda_q;
    assign ad_clk_sel      = ad_clk_sel_q;
    assign ad_clk_en       = ad_clk_en_q;
    assign par_hor         = par_hor_q;
    assign fft_start_pulse = fft_start_q;
    assign fft_armed       = fft_armed_q;
    assign adclk_busy      = adclk_busy_q;
    assign cfg_err         = cfg_err_q;

`ifdef SCOPE_MODE_CTRL_READBACK_EN
    // Combinational register readback
    always_comb begin
        cpu_rdata = 8'h00;
        case (cpu_addr)
            A_WAVE:  cpu_rdata = {6'b0, wave_q};
            A_FRQ:   cpu_rdata = {6'b0, frq_q};
            A_ADDA:  cpu_rdata = {7'b0, adda_q};
            A_ADCLK: cpu_rdata = {5'b0, adclk_q};
            A_HOR:   cpu_rdata = {6'b0, hor_q};
            A_STAT:  cpu_rdata = {6'b0, adclk_busy_q, fft_armed_q};
            default: cpu_rdata = 8'h00;
        endcase
    end
`else
    assign cpu_rdata = 8'h00;
`endif

endmodule
